// File: rtl/frame_color_classifier_if.sv
// Pixel-scan input and per-frame verdict bundle between the VGA side and the colour classifier.
// The master drives the scan and pixel data; the slave (classifier) publishes the verdict.
interface frame_color_classifier_if #(
  parameter int unsigned COUNT_W = 15
);
  logic [7:0]         PIXEL_IN;
  logic [9:0]         VGA_PIXEL_X;
  logic [9:0]         VGA_PIXEL_Y;
  logic               VGA_VSYNC_NEG;
  logic [8:0]         RESULT;
  logic               RESULT_VALID;
  logic [COUNT_W-1:0] RED_TOTAL;
  logic [COUNT_W-1:0] BLUE_TOTAL;

  modport master (
    output PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
    input  RESULT, RESULT_VALID, RED_TOTAL, BLUE_TOTAL
  );

  modport slave (
    input  PIXEL_IN, VGA_PIXEL_X, VGA_PIXEL_Y, VGA_VSYNC_NEG,
    output RESULT, RESULT_VALID, RED_TOTAL, BLUE_TOTAL
  );
endinterface

// File: rtl/frame_color_classifier.sv
// Counts red/blue RGB332 pixels per horizontal third of the image window and
// publishes a colour/position/frame-count verdict once per vertical sync.
module frame_color_classifier #(
  parameter int unsigned SCREEN_WIDTH  = 176,
  parameter int unsigned SCREEN_HEIGHT = 144,
  parameter int unsigned COUNT_W       = 15,
  parameter int unsigned MIN_PIXELS    = 400,
  parameter int unsigned R_MIN         = 5,
  parameter int unsigned B_MIN         = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  frame_color_classifier_if.slave  bus
);

  localparam int unsigned SUM_W   = COUNT_W + 2;
  localparam int unsigned THIRD_L = SCREEN_WIDTH / 3;
  localparam int unsigned THIRD_C = (2 * SCREEN_WIDTH) / 3;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

  state_t             state;
  logic [9:0]         dx;
  logic [9:0]         dy;
  logic               prev_vsync;
  logic [COUNT_W-1:0] red_cnt  [3];
  logic [COUNT_W-1:0] blue_cnt [3];
  logic [4:0]         frame_cnt;
  logic [8:0]         result_q;
  logic               result_valid_q;
  logic [COUNT_W-1:0] red_total_q;
  logic [COUNT_W-1:0] blue_total_q;

  logic [2:0]         pix_r_c;
  logic [2:0]         pix_g_c;
  logic [1:0]         pix_b_c;
  logic               is_red_c;
  logic               is_blue_c;
  logic               in_win_c;
  logic               vs_fall_c;
  logic [1:0]         third_c;

  // Pixel data lags the coordinates by one cycle, so classify against dx/dy
  assign pix_r_c   = bus.PIXEL_IN[7:5];
  assign pix_g_c   = bus.PIXEL_IN[4:2];
  assign pix_b_c   = bus.PIXEL_IN[1:0];
  assign is_red_c  = (pix_r_c >= 3'(R_MIN)) && (pix_g_c <= 3'd2) && (pix_b_c <= 2'd1);
  assign is_blue_c = (pix_b_c >= 2'(B_MIN)) && (pix_r_c <= 3'd2) && (pix_g_c <= 3'd2);
  assign in_win_c  = (dx < 10'(SCREEN_WIDTH)) && (dy < 10'(SCREEN_HEIGHT));
  assign vs_fall_c = prev_vsync & ~bus.VGA_VSYNC_NEG;
  assign third_c   = (dx < 10'(THIRD_L)) ? 2'd0 :
                     (dx < 10'(THIRD_C)) ? 2'd1 : 2'd2;

  logic [SUM_W-1:0]   red_sum_c;
  logic [SUM_W-1:0]   blue_sum_c;
  logic [COUNT_W-1:0] red_tot_c;
  logic [COUNT_W-1:0] blue_tot_c;
  logic [COUNT_W-1:0] win_l_c;
  logic [COUNT_W-1:0] win_m_c;
  logic [COUNT_W-1:0] win_r_c;
  logic [1:0]         colour_c;
  logic [1:0]         pos_c;

  // Frame verdict from the frozen counters; position ties go centre, then left
  always_comb begin
    red_sum_c  = SUM_W'(red_cnt[0]) + SUM_W'(red_cnt[1]) + SUM_W'(red_cnt[2]);
    blue_sum_c = SUM_W'(blue_cnt[0]) + SUM_W'(blue_cnt[1]) + SUM_W'(blue_cnt[2]);
    red_tot_c  = (red_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : red_sum_c[COUNT_W-1:0];
    blue_tot_c = (blue_sum_c > SUM_W'(CNT_MAX)) ? CNT_MAX : blue_sum_c[COUNT_W-1:0];

    colour_c = 2'b00;
    if ((red_tot_c >= COUNT_W'(MIN_PIXELS)) && (red_tot_c > blue_tot_c)) begin
      colour_c = 2'b01;
    end else if ((blue_tot_c >= COUNT_W'(MIN_PIXELS)) && (blue_tot_c > red_tot_c)) begin
      colour_c = 2'b10;
    end

    win_l_c = (colour_c == 2'b10) ? blue_cnt[0] : red_cnt[0];
    win_m_c = (colour_c == 2'b10) ? blue_cnt[1] : red_cnt[1];
    win_r_c = (colour_c == 2'b10) ? blue_cnt[2] : red_cnt[2];

    pos_c = 2'b00;
    if (colour_c != 2'b00) begin
      if ((win_m_c >= win_l_c) && (win_m_c >= win_r_c)) begin
        pos_c = 2'b10;
      end else if (win_l_c >= win_r_c) begin
        pos_c = 2'b01;
      end else begin
        pos_c = 2'b11;
      end
    end
  end

  // Frame state machine, counters and registered verdict
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      dx             <= '0;
      dy             <= '0;
      prev_vsync     <= 1'b1;
      frame_cnt      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      red_total_q    <= '0;
      blue_total_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        red_cnt[i]  <= '0;
        blue_cnt[i] <= '0;
      end
    end else begin
      dx             <= bus.VGA_PIXEL_X;
      dy             <= bus.VGA_PIXEL_Y;
      prev_vsync     <= bus.VGA_VSYNC_NEG;
      result_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (vs_fall_c) begin
            for (int i = 0; i < 3; i++) begin
              red_cnt[i]  <= '0;
              blue_cnt[i] <= '0;
            end
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (vs_fall_c) begin
            state <= DECIDE;
          end else if (in_win_c) begin
            if (is_red_c && (red_cnt[third_c] != CNT_MAX)) begin
              red_cnt[third_c] <= red_cnt[third_c] + COUNT_W'(1);
            end
            if (is_blue_c && (blue_cnt[third_c] != CNT_MAX)) begin
              blue_cnt[third_c] <= blue_cnt[third_c] + COUNT_W'(1);
            end
          end
        end
        DECIDE: begin
          result_q       <= {frame_cnt + 5'd1, pos_c, colour_c};
          red_total_q    <= red_tot_c;
          blue_total_q   <= blue_tot_c;
          result_valid_q <= 1'b1;
          frame_cnt      <= frame_cnt + 5'd1;
          for (int i = 0; i < 3; i++) begin
            red_cnt[i]  <= '0;
            blue_cnt[i] <= '0;
          end
          state <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = result_valid_q;
  assign bus.RED_TOTAL    = red_total_q;
  assign bus.BLUE_TOTAL   = blue_total_q;

endmodule

// File: tb/tb_frame_color_classifier.sv
// Self-checking bench for frame_color_classifier: directed frame table, hand-written
// reset/vsync/wrap sequences and random frames checked against a per-frame count model.
module tb_frame_color_classifier;

  localparam int unsigned COUNT_W = 15;
  localparam int W = 176;
  localparam int H = 144;

  logic CLK = 1'b0;
  logic RESET_N;

  frame_color_classifier_if #(.COUNT_W(COUNT_W)) bus ();

  frame_color_classifier #(.COUNT_W(COUNT_W)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #20 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model state: per-class (0 red, 1 blue) per-third counts for the current frame
  int         mcnt [2][3];
  logic [4:0] mframe = 5'd0;
  logic [7:0] pend = 8'h00;

  // Monitor: every cycle RESULT_VALID is high is one captured pulse cycle
  int                 pulse_cnt = 0;
  logic [8:0]         cap_res   = '0;
  logic [COUNT_W-1:0] cap_red   = '0;
  logic [COUNT_W-1:0] cap_blue  = '0;

  always @(negedge CLK) begin
    if (bus.RESULT_VALID === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      cap_res   = bus.RESULT;
      cap_red   = bus.RED_TOTAL;
      cap_blue  = bus.BLUE_TOTAL;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [7:0] p);
    int r, g, b;
    r = int'(p >> 5);
    g = int'((p >> 2) & 8'h07);
    b = int'(p & 8'h03);
    if (r >= 5 && g <= 2 && b <= 1) return 0;
    if (b >= 2 && r <= 2 && g <= 2) return 1;
    return 2;
  endfunction

  function automatic int third_of(input int x);
    if (x < W / 3) return 0;
    if (x < (2 * W) / 3) return 1;
    return 2;
  endfunction

  function automatic void clear_model();
    for (int c = 0; c < 2; c++)
      for (int t = 0; t < 3; t++) mcnt[c][t] = 0;
  endfunction

  // Drive one scan position; its pixel data follows one cycle later
  task automatic push(input int x, input int y, input logic [7:0] p, input logic vs);
    int k;
    @(negedge CLK);
    bus.VGA_PIXEL_X   = 10'(x);
    bus.VGA_PIXEL_Y   = 10'(y);
    bus.VGA_VSYNC_NEG = vs;
    bus.PIXEL_IN      = pend;
    pend              = p;
    if (x < W && y < H) begin
      k = classify(p);
      if (k < 2) mcnt[k][third_of(x)]++;
    end
  endtask

  function automatic void model_decide(output int rt, output int bt,
                                       output logic [1:0] col, output logic [1:0] pos);
    int c [3];
    int m;
    rt = mcnt[0][0] + mcnt[0][1] + mcnt[0][2];
    bt = mcnt[1][0] + mcnt[1][1] + mcnt[1][2];
    if (rt > 32767) rt = 32767;
    if (bt > 32767) bt = 32767;
    col = 2'd0;
    if (rt >= 400 && rt > bt) col = 2'd1;
    else if (bt >= 400 && bt > rt) col = 2'd2;
    pos = 2'd0;
    if (col != 2'd0) begin
      for (int t = 0; t < 3; t++) c[t] = mcnt[(col == 2'd1) ? 0 : 1][t];
      m = c[0];
      if (c[1] > m) m = c[1];
      if (c[2] > m) m = c[2];
      if (c[1] == m) pos = 2'd2;
      else if (c[0] == m) pos = 2'd1;
      else pos = 2'd3;
    end
  endfunction

  // Close the frame with a vsync low of low_len cycles and check the verdict
  task automatic end_frame(input bit exp_pulse, input int low_len, input string tag);
    int base, rt, bt;
    logic [1:0] col, pos;
    logic [8:0] exp_res;
    push(800, 600, 8'h00, 1'b1);
    push(800, 600, 8'h00, 1'b1);
    base = pulse_cnt;
    for (int i = 0; i < low_len; i++) push(800, 600, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) push(800, 600, 8'h00, 1'b1);
    model_decide(rt, bt, col, pos);
    check({tag, " pulse_cycles"}, 32'(pulse_cnt - base), exp_pulse ? 32'd1 : 32'd0);
    if (exp_pulse) begin
      mframe  = mframe + 5'd1;
      exp_res = {mframe, pos, col};
      check({tag, " result"}, 32'(cap_res), 32'(exp_res));
      check({tag, " red_total"}, 32'(cap_red), 32'(rt));
      check({tag, " blue_total"}, 32'(cap_blue), 32'(bt));
      check({tag, " result_hold"}, 32'(bus.RESULT), 32'(exp_res));
      check({tag, " valid_low_after"}, 32'(bus.RESULT_VALID), 32'd0);
    end
    clear_model();
  endtask

  typedef struct {
    logic [7:0] pix;
    int         x;
    int         y;
    int         n;
    logic [1:0] exp_col;
    logic [1:0] exp_pos;
    int         exp_red;
    int         exp_blue;
  } frame_vec_t;

  frame_vec_t vecs [13];

  initial begin
    vecs[0]  = '{8'hE0,   0,   0, 450, 2'd1, 2'd1, 450,   0};
    vecs[1]  = '{8'hA0,  57,  10, 450, 2'd1, 2'd1, 450,   0};
    vecs[2]  = '{8'hA8,  58,  10, 450, 2'd1, 2'd2, 450,   0};
    vecs[3]  = '{8'hE6,  30,  20, 450, 2'd0, 2'd0,   0,   0};
    vecs[4]  = '{8'hC0, 116,  50, 450, 2'd1, 2'd2, 450,   0};
    vecs[5]  = '{8'h80, 117,  50, 450, 2'd0, 2'd0,   0,   0};
    vecs[6]  = '{8'h03, 117,  60, 450, 2'd2, 2'd3,   0, 450};
    vecs[7]  = '{8'h4A, 175, 143, 450, 2'd2, 2'd3,   0, 450};
    vecs[8]  = '{8'h0D,  90,  70, 450, 2'd0, 2'd0,   0,   0};
    vecs[9]  = '{8'h02, 176,  10, 450, 2'd0, 2'd0,   0,   0};
    vecs[10] = '{8'hE0,  10, 144, 450, 2'd0, 2'd0,   0,   0};
    vecs[11] = '{8'h52,  60,  60, 450, 2'd0, 2'd0,   0,   0};
    vecs[12] = '{8'hE0,   0,   0, 399, 2'd0, 2'd0, 399,   0};

    clear_model();
    bus.PIXEL_IN      = 8'h00;
    bus.VGA_PIXEL_X   = 10'd800;
    bus.VGA_PIXEL_Y   = 10'd600;
    bus.VGA_VSYNC_NEG = 1'b1;
    RESET_N           = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset result", 32'(bus.RESULT), 32'd0);
    check("reset valid", 32'(bus.RESULT_VALID), 32'd0);
    check("reset red_total", 32'(bus.RED_TOTAL), 32'd0);
    check("reset blue_total", 32'(bus.BLUE_TOTAL), 32'd0);
    RESET_N = 1'b1;

    // Pixels before the first vsync are never reported
    for (int i = 0; i < 600; i++) push(i % W, i / W, 8'hE0, 1'b1);
    end_frame(1'b0, 2, "first_vsync");

    // Whole window red: centre/right tie goes to centre
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) push(x, y, 8'hE0, 1'b1);
    end_frame(1'b1, 3, "all_red");
    check("all_red red_total_const", 32'(cap_red), 32'd25344);
    check("all_red code_const", 32'(cap_res[3:0]), 32'b1001);

    // Left third only, plus red in blanking that must be ignored
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W / 3; x++) push(x, y, 8'hE0, 1'b1);
    for (int i = 0; i < 20; i++) push(180 + i, i, 8'hE0, 1'b1);
    for (int i = 0; i < 20; i++) push(i, 150 + i, 8'hE0, 1'b1);
    end_frame(1'b1, 3, "left_red");
    check("left_red red_total_const", 32'(cap_red), 32'd8352);

    // Blue right third beats 500 centre red
    for (int y = 0; y < H; y++)
      for (int x = 117; x < W; x++) push(x, y, 8'h03, 1'b1);
    for (int i = 0; i < 500; i++) push(60 + (i % 50), i / 50, 8'hE0, 1'b1);
    end_frame(1'b1, 3, "right_blue");
    check("right_blue blue_total_const", 32'(cap_blue), 32'd8496);

    // Below threshold: pulse still fires, colour none
    for (int i = 0; i < 300; i++) push(i % W, i / W, 8'hE0, 1'b1);
    end_frame(1'b1, 3, "few_red");

    // Equal totals give none; vsync held low over many cycles gives one verdict
    for (int i = 0; i < 1000; i++) begin
      push(i % W, i / W, 8'hE0, 1'b1);
      push(i % W, 20 + i / W, 8'h03, 1'b1);
    end
    end_frame(1'b1, 25, "equal");
    check("equal code_const", 32'(cap_res[3:0]), 32'd0);

    // Directed single-pixel-value frames from the table
    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < vecs[v].n; i++) push(vecs[v].x, vecs[v].y, vecs[v].pix, 1'b1);
      end_frame(1'b1, 2, $sformatf("vec%0d", v));
      check($sformatf("vec%0d colour", v), 32'(cap_res[1:0]), 32'(vecs[v].exp_col));
      check($sformatf("vec%0d position", v), 32'(cap_res[3:2]), 32'(vecs[v].exp_pos));
      check($sformatf("vec%0d red", v), 32'(cap_red), 32'(vecs[v].exp_red));
      check($sformatf("vec%0d blue", v), 32'(cap_blue), 32'(vecs[v].exp_blue));
    end

    // Random frames with a per-frame colour bias
    for (int f = 0; f < 6; f++) begin
      int red_w;
      red_w = (f % 3 == 0) ? 6 : (f % 3 == 1) ? 2 : 4;
      for (int i = 0; i < 1500; i++) begin
        int sel;
        logic [7:0] p;
        sel = int'($urandom_range(0, 9));
        if (sel < red_w)
          p = {3'($urandom_range(5, 7)), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 1))};
        else if (sel < 8)
          p = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), 2'($urandom_range(2, 3))};
        else
          p = 8'($urandom);
        push(int'($urandom_range(0, 199)), int'($urandom_range(0, 159)), p, 1'b1);
      end
      end_frame(1'b1, int'($urandom_range(1, 6)), $sformatf("rand%0d", f));
    end

    // Asynchronous reset mid-frame clears outputs without a clock edge
    for (int i = 0; i < 200; i++) push(i % W, 5, 8'hE0, 1'b1);
    @(negedge CLK);
    #5 RESET_N = 1'b0;
    #1;
    check("midreset result", 32'(bus.RESULT), 32'd0);
    check("midreset valid", 32'(bus.RESULT_VALID), 32'd0);
    check("midreset red_total", 32'(bus.RED_TOTAL), 32'd0);
    check("midreset blue_total", 32'(bus.BLUE_TOTAL), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    mframe  = 5'd0;
    clear_model();
    for (int i = 0; i < 300; i++) push(i % W, 7, 8'hE0, 1'b1);
    end_frame(1'b0, 2, "post_reset_first");
    for (int i = 0; i < 500; i++) push(i % W, 9 + i / W, 8'h03, 1'b1);
    end_frame(1'b1, 2, "post_reset_second");
    check("post_reset frame_count", 32'(cap_res[8:4]), 32'd1);

    // Empty frames until the 5-bit frame count wraps
    for (int f = 0; f < 31; f++) end_frame(1'b1, 1, $sformatf("wrap%0d", f));
    check("wrap frame_count", 32'(cap_res[8:4]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
